uart_rx_deframer: RTL and testbench

UART receive deframer placed directly downstream of the input filter. It consumes the filtered serial line and the oversampling tick RXC, detects the start bit, samples each bit at mid-period, checks optional parity and the stop bit, and presents the received word through a valid/acknowledge holding register. It sits between the input filter and the host-side receive interface or FIFO.

---
 rtl/uart_rx_deframer.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//   UART receive deframer. Consumes the filtered serial line and the
//   oversampling enable, finds the start bit, samples every bit at mid-period,
//   checks optional parity and the stop bit, and presents the received word
//   through a valid/acknowledge holding register.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9), LSB first
//   OVERSAMPLE  RXC ticks per bit period (even, >= 4)
//   PARITY_EN   1 = one parity bit follows the data bits
//   PARITY_ODD  1 = odd parity, 0 = even parity
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   RXC          oversample enable, one CLK wide
//   RXD          filtered serial data, idle high
//   DATA_ACK     host consumed the held word (single-cycle pulse)
//   DATA_OUT     received word
//   DATA_VALID   holding register contains a frame
//   FRAME_ERR    stop bit of the held frame sampled low
//   PARITY_ERR   parity mismatch on the held frame
//   OVERRUN_ERR  sticky: a frame was dropped because the register was full
//   BUSY         receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RXC,
  input  logic                 RXD,
  input  logic                 DATA_ACK,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN_ERR,
  output logic                 BUSY
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Receiver state
  state_e                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   armed_q, armed_d;
  logic                   busy_q, busy_d;

  // Holding register
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   ovr_q, ovr_d;

  logic                   done;
  logic                   bit_end;
  logic                   mid_start;

  assign bit_end   = (tick_q == TICK_LAST);
  assign mid_start = (tick_q == TICK_HALF);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    armed_d = armed_q;
    done    = 1'b0;

    if (RXC) begin
      unique case (state_q)
        S_IDLE: begin
          // After a framing error (e.g. a break) the line must be seen high
          // once before a falling sample is accepted as a new start bit.
          if (RXD) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (mid_start) begin
            tick_d = '0;
            if (RXD) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            tick_d  = '0;
            shift_d = {RXD, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = HAS_PAR ? S_PARITY : S_STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tick_d  = '0;
            par_d   = (^shift_q) ^ RXD ^ ODD;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = S_IDLE;
            armed_d = RXD;
            done    = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          bit_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // Holding register: a completing frame wins over a plain acknowledge; an
  // acknowledge in the completion cycle frees the slot for the new frame.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;

    if (done) begin
      if (!valid_q || DATA_ACK) begin
        dout_d  = shift_q;
        ferr_d  = ~RXD;
        perr_d  = HAS_PAR & par_q;
        valid_d = 1'b1;
        if (DATA_ACK) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (DATA_ACK && valid_q) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      armed_q <= 1'b1;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign DATA_OUT    = dout_q;
  assign DATA_VALID  = valid_q;
  assign FRAME_ERR   = ferr_q;
  assign PARITY_ERR  = perr_q;
  assign OVERRUN_ERR = ovr_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//   Two instances: dut0 without parity, dut1 with even parity. Directed frames
//   push their expected word into a per-instance queue; a monitor pops and
//   compares whenever an instance presents a new word.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       RXC   = 1'b0;
  logic       rxd0  = 1'b1;
  logic       rxd1  = 1'b1;
  logic       ack0  = 1'b0;
  logic       ack1  = 1'b0;

  logic [7:0] dout0, dout1;
  logic       v0, fe0, pe0, ov0, b0;
  logic       v1, fe1, pe1, ov1, b1;

  exp_t       q0[$];
  exp_t       q1[$];

  int         n_checks = 0;
  int         n_fail   = 0;

  logic       pv0 = 1'b0, pv1 = 1'b0;
  logic       mon_a0, mon_a1;

  uart_rx_deframer #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (0),
    .PARITY_ODD(0)
  ) dut0 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RXC        (RXC),
    .RXD        (rxd0),
    .DATA_ACK   (ack0),
    .DATA_OUT   (dout0),
    .DATA_VALID (v0),
    .FRAME_ERR  (fe0),
    .PARITY_ERR (pe0),
    .OVERRUN_ERR(ov0),
    .BUSY       (b0)
  );

  uart_rx_deframer #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut1 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RXC        (RXC),
    .RXD        (rxd1),
    .DATA_ACK   (ack1),
    .DATA_OUT   (dout1),
    .DATA_VALID (v1),
    .FRAME_ERR  (fe1),
    .PARITY_ERR (pe1),
    .OVERRUN_ERR(ov1),
    .BUSY       (b1)
  );

  always #5 CLK = ~CLK;

  // RXC high one CLK out of every four
  initial begin
    int unsigned c;
    c = 0;
    forever begin
      @(negedge CLK);
      RXC = (c == 3);
      c   = (c + 1) % 4;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int which);
    exp_t e;
    if (which == 0) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut0_unexpected: got 0x%0h expected no frame", dout0);
      end else begin
        e = q0.pop_front();
        chk("dut0_data", {24'd0, dout0}, {24'd0, e.d});
        chk("dut0_frame_err", {31'd0, fe0}, {31'd0, e.fe});
        chk("dut0_parity_err", {31'd0, pe0}, {31'd0, e.pe});
      end
    end else begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_unexpected: got 0x%0h expected no frame", dout1);
      end else begin
        e = q1.pop_front();
        chk("dut1_data", {24'd0, dout1}, {24'd0, e.d});
        chk("dut1_frame_err", {31'd0, fe1}, {31'd0, e.fe});
        chk("dut1_parity_err", {31'd0, pe1}, {31'd0, e.pe});
      end
    end
  endtask

  // A new word is presented when DATA_VALID rises, or stays high across an
  // edge at which DATA_ACK was applied (reload in the completion cycle).
  always @(posedge CLK) begin
    mon_a0 = ack0;
    mon_a1 = ack1;
    #1;
    if (RST_N && v0 && (!pv0 || mon_a0)) pop_check(0);
    if (RST_N && v1 && (!pv1 || mon_a1)) pop_check(1);
    pv0 = v0;
    pv1 = v1;
  end

  task automatic tick();
    @(posedge CLK);
    while (RXC !== 1'b1) @(posedge CLK);
    #1;
  endtask

  task automatic set_rxd(input int which, input logic v);
    if (which == 0) rxd0 = v;
    else            rxd1 = v;
  endtask

  task automatic set_ack(input int which, input logic v);
    if (which == 0) ack0 = v;
    else            ack1 = v;
  endtask

  task automatic pulse_ack(input int which);
    @(negedge CLK);
    set_ack(which, 1'b1);
    @(negedge CLK);
    set_ack(which, 1'b0);
    #1;
  endtask

  // Full frame: start, 8 data bits LSB first, parity (dut1 only), stop.
  // The stop bit is sampled on its 9th tick; ack_stop asserts DATA_ACK in
  // exactly that RXC cycle.
  task automatic send_frame(input int which, input logic [7:0] d, input logic par,
                            input logic stop, input bit ack_stop, input bit chk_lat);
    set_rxd(which, 1'b0);
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      set_rxd(which, d[i]);
      repeat (16) tick();
    end
    if (which == 1) begin
      set_rxd(which, par);
      repeat (16) tick();
    end
    set_rxd(which, stop);
    repeat (8) tick();
    repeat (3) @(posedge CLK);
    #2;
    if (ack_stop) set_ack(which, 1'b1);
    if (chk_lat) chk("valid_before_stop_tick", {31'd0, v0}, 32'd0);
    tick();
    if (chk_lat) begin
      chk("valid_one_clk_after_stop_tick", {31'd0, v0}, 32'd1);
      chk("busy_after_stop_tick", {31'd0, b0}, 32'd0);
    end
    set_ack(which, 1'b0);
    repeat (7) tick();
    set_rxd(which, 1'b1);
  endtask

  initial begin
    int busy_cnt;
    int guard;

    // Reset state
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_busy", {31'd0, b0}, 32'd0);
    chk("rst_flags", {29'd0, fe0, pe0, ov0}, 32'd0);
    chk("rst_dout", {24'd0, dout0}, 32'd0);
    chk("rst_valid_p", {31'd0, v1}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) tick();

    // 1. 0xA5, good stop, latency check
    q0.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_ack(0);
    chk("t1_valid_cleared", {31'd0, v0}, 32'd0);
    repeat (4) tick();

    // 2. False start: 6 low ticks
    busy_cnt = 0;
    set_rxd(0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) set_rxd(0, 1'b1);
      tick();
      busy_cnt += int'(b0);
    end
    chk("t2_busy_ticks", busy_cnt, 32'd8);
    chk("t2_no_valid", {31'd0, v0}, 32'd0);

    // 3. 0x3C with stop bit 0, then acknowledge
    q0.push_back('{d: 8'h3C, fe: 1'b1, pe: 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("t3_frame_err_held", {31'd0, fe0}, 32'd1);
    pulse_ack(0);
    chk("t3_valid_cleared", {31'd0, v0}, 32'd0);
    chk("t3_frame_err_cleared", {31'd0, fe0}, 32'd0);
    chk("t3_dout_kept", {24'd0, dout0}, 32'h3C);
    repeat (2) tick();

    // 4. Even parity on dut1
    q1.push_back('{d: 8'h81, fe: 1'b0, pe: 1'b0});
    send_frame(1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_ack(1);
    repeat (2) tick();
    q1.push_back('{d: 8'h81, fe: 1'b0, pe: 1'b1});
    send_frame(1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_parity_err_held", {31'd0, pe1}, 32'd1);
    pulse_ack(1);
    chk("t4_parity_err_cleared", {31'd0, pe1}, 32'd0);
    repeat (2) tick();

    // 5a. Back-to-back without acknowledge: second frame dropped
    q0.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5a_overrun", {31'd0, ov0}, 32'd1);
    chk("t5a_dout_held", {24'd0, dout0}, 32'h11);
    chk("t5a_valid", {31'd0, v0}, 32'd1);
    pulse_ack(0);
    chk("t5a_overrun_cleared", {31'd0, ov0}, 32'd0);
    chk("t5a_valid_cleared", {31'd0, v0}, 32'd0);
    repeat (2) tick();

    // 5b. Acknowledge in the second frame's completion cycle
    q0.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    q0.push_back('{d: 8'h22, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5b_no_overrun", {31'd0, ov0}, 32'd0);
    chk("t5b_dout", {24'd0, dout0}, 32'h22);
    chk("t5b_valid", {31'd0, v0}, 32'd1);
    pulse_ack(0);
    repeat (2) tick();

    // Break: line held low well past the stop sample; no restart until high
    q0.push_back('{d: 8'h00, fe: 1'b1, pe: 1'b0});
    set_rxd(0, 1'b0);
    repeat (200) tick();
    chk("brk_idle_while_low", {31'd0, b0}, 32'd0);
    chk("brk_frame_err", {31'd0, fe0}, 32'd1);
    set_rxd(0, 1'b1);
    repeat (2) tick();
    pulse_ack(0);
    repeat (2) tick();

    // 6. Reset during data bit 4 of 0xFF, then 0x5A
    set_rxd(0, 1'b0);
    repeat (16) tick();
    set_rxd(0, 1'b1);
    repeat (72) tick();
    chk("t6_busy_mid_frame", {31'd0, b0}, 32'd1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("t6_busy_in_reset", {31'd0, b0}, 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) tick();
    chk("t6_no_valid_after_reset", {31'd0, v0}, 32'd0);
    chk("t6_no_flags_after_reset", {29'd0, fe0, pe0, ov0}, 32'd0);
    q0.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_flags_clean", {29'd0, fe0, pe0, ov0}, 32'd0);
    pulse_ack(0);
    repeat (2) tick();

    // All expected words must have been presented
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
      @(posedge CLK);
      guard++;
    end
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
